// File: rtl/shift194_pkg.sv
// Shared opcodes, 74LS194 mode codes, FSM encoding and opcode decode helpers.
// Opcode 110 is only treated as legal when SHIFT_CTRL_TWIST_EN is defined.
package shift194_pkg;

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_LOAD     = 3'b001;
  localparam logic [2:0] OP_ROTR     = 3'b010;
  localparam logic [2:0] OP_ROTL     = 3'b011;
  localparam logic [2:0] OP_SHR_FILL = 3'b100;
  localparam logic [2:0] OP_SHL_FILL = 3'b101;
  localparam logic [2:0] OP_TWIST    = 3'b110;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic op_is_shift(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ROTR, OP_ROTL, OP_SHR_FILL, OP_SHL_FILL: r = 1'b1;
`ifdef SHIFT_CTRL_TWIST_EN
      OP_TWIST: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_NOP) || (op == OP_LOAD) || op_is_shift(op);
  endfunction

  // Left-moving ops feed SL; everything else that shifts moves right.
  function automatic logic [1:0] op_mode(input logic [2:0] op);
    logic [1:0] m;
    case (op)
      OP_ROTL, OP_SHL_FILL: m = MODE_SHL;
      default:              m = MODE_SHR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/shift194_fb_mux.sv
// Serial-input selection for the 74LS194 SL/SR pins while a shift command runs.
// The inverted-QD twist path exists only when SHIFT_CTRL_TWIST_EN is defined.
module shift194_fb_mux
  import shift194_pkg::*;
(
  input  logic       run,
  input  logic [2:0] op,
  input  logic       fill,
  input  logic [3:0] q_in,
  output logic       sl,
  output logic       sr
);

  logic unused_q_mid;
  assign unused_q_mid = ^q_in[2:1];

  always_comb begin
    sl = 1'b0;
    sr = 1'b0;
    if (run) begin
      case (op)
        OP_ROTR:     sr = q_in[0];
        OP_ROTL:     sl = q_in[3];
        OP_SHR_FILL: sr = fill;
        OP_SHL_FILL: sl = fill;
`ifdef SHIFT_CTRL_TWIST_EN
        OP_TWIST:    sr = ~q_in[0];
`endif
        default: begin
          sl = 1'b0;
          sr = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift194_ctrl.sv
// Command sequencer for a DM74LS194: drives S1/S0, A-D and SL/SR for N edges.
// Build option SHIFT_CTRL_TWIST_EN enables opcode 110 (Johnson right shift).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | cmd_ready high, mode held; NOP/count0/illegal finish here
// ST_RUN  | register operating; count_q edges remain including this one
module shift194_ctrl
  import shift194_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             CR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [3:0]       q_in,
  output logic             S1,
  output logic             S0,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             SL,
  output logic             SR,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             starts_run;

  assign accept     = cmd_valid && (state_q == ST_IDLE);
  assign starts_run = (cmd_op == OP_LOAD) ||
                      (op_is_shift(cmd_op) && (cmd_count != '0));

  always_ff @(posedge clk or negedge CR) begin
    if (!CR) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && starts_run) state_d = ST_RUN;
      ST_RUN:  if (count_q <= CNT_ONE)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    op_d    = op_q;
    fill_d  = fill_q;
    mode_d  = mode_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          fill_d = cmd_fill;
          if (cmd_op == OP_LOAD) begin
            mode_d  = MODE_LOAD;
            data_d  = cmd_data;
            count_d = CNT_ONE;
          end else if (starts_run) begin
            mode_d  = op_mode(cmd_op);
            count_d = cmd_count;
          end else begin
            done_d = 1'b1;
            err_d  = !op_is_legal(cmd_op);
          end
        end
      end
      ST_RUN: begin
        // Mode drops to hold on the same edge as the last operation.
        if (count_q <= CNT_ONE) begin
          count_d = '0;
          mode_d  = MODE_HOLD;
          done_d  = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      default: begin
        count_d = '0;
        mode_d  = MODE_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge CR) begin
    if (!CR) begin
      count_q <= '0;
      op_q    <= OP_NOP;
      fill_q  <= 1'b0;
      mode_q  <= MODE_HOLD;
      data_q  <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  shift194_fb_mux u_fb_mux (
    .run  (state_q == ST_RUN),
    .op   (op_q),
    .fill (fill_q),
    .q_in (q_in),
    .sl   (SL),
    .sr   (SR)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign err       = err_q;
  assign S1        = mode_q[1];
  assign S0        = mode_q[0];
  assign A         = data_q[3];
  assign B         = data_q[2];
  assign C         = data_q[1];
  assign D         = data_q[0];

endmodule

// File: tb/tb_shift194_ctrl.sv
// Bench for shift194_ctrl driving a behavioural 74LS194; scoreboard of Q values
// and done/err events. Honours SHIFT_CTRL_TWIST_EN for the opcode 110 case.
module tb_shift194_ctrl;

  localparam logic [2:0] T_NOP = 3'd0, T_LOAD = 3'd1, T_ROTR = 3'd2, T_ROTL = 3'd3;
  localparam logic [2:0] T_SHRF = 3'd4, T_SHLF = 3'd5, T_TWIST = 3'd6, T_RSVD = 3'd7;

  logic       clk = 1'b0;
  logic       CR = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_fill = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic [3:0] q;
  logic       cmd_ready, S1, S0, A, B, C, D, SL, SR, busy, done, err;

  typedef struct {
    logic err;
    int   cyc;
  } done_exp_t;

  logic [3:0] exp_q[$];
  done_exp_t  done_q[$];
  logic [3:0] model_q = 4'd0;
  logic [1:0] mode_prev = 2'b00;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  shift194_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .CR(CR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_fill(cmd_fill), .cmd_count(cmd_count),
    .q_in(q), .S1(S1), .S0(S0), .A(A), .B(B), .C(C), .D(D), .SL(SL), .SR(SR),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural DM74LS194, bit3 = QA.
  always @(posedge clk or negedge CR) begin
    if (!CR) q <= 4'b0000;
    else begin
      case ({S1, S0})
        2'b01:   q <= {SR, q[3:1]};
        2'b10:   q <= {q[2:0], SL};
        2'b11:   q <= {A, B, C, D};
        default: q <= q;
      endcase
    end
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic twist_legal();
`ifdef SHIFT_CTRL_TWIST_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] step(input logic [2:0] op, input logic [3:0] m, input logic f);
    case (op)
      T_ROTR:  return {m[0], m[3:1]};
      T_ROTL:  return {m[2:0], m[3]};
      T_SHRF:  return {f, m[3:1]};
      T_SHLF:  return {m[2:0], f};
      default: return {~m[0], m[3:1]};
    endcase
  endfunction

  // Scoreboard consumer: one Q check per edge the register was told to act on.
  always @(negedge clk) begin
    done_exp_t d;
    logic [3:0] e;
    if (!CR) mode_prev = 2'b00;
    else begin
      if (mode_prev != 2'b00) begin
        if (exp_q.size() == 0) check("extra_op", {30'd0, mode_prev}, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("q", {28'd0, q}, {28'd0, e});
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexp_done", 32'd1, 32'd0);
        else begin
          d = done_q.pop_front();
          check("err", {31'd0, err}, {31'd0, d.err});
          check("done_cyc", cyc, d.cyc);
          check("q_left", exp_q.size(), 32'd0);
          check("ready_at_done", {31'd0, cmd_ready}, 32'd1);
          check("mode_at_done", {30'd0, S1, S0}, 32'd0);
        end
      end
      mode_prev = {S1, S0};
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic fill,
                       input logic [3:0] cnt);
    done_exp_t d;
    int n;
    bit got;
    cmd_op = op; cmd_data = data; cmd_fill = fill; cmd_count = cnt;
    cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (cmd_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    n = 0;
    d.err = 1'b0;
    if (op == T_LOAD) begin
      model_q = data;
      exp_q.push_back(model_q);
      n = 1;
    end else if ((op >= T_ROTR && op <= T_SHLF) || (op == T_TWIST && twist_legal())) begin
      for (int i = 0; i < int'(cnt); i++) begin
        model_q = step(op, model_q, fill);
        exp_q.push_back(model_q);
      end
      n = int'(cnt);
    end else if (op != T_NOP) begin
      d.err = 1'b1;
    end
    d.cyc = cyc + 1 + n;
    done_q.push_back(d);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_fill = ~fill;
    cmd_data = ~data;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && done_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      check("drain_timeout", done_q.size() + exp_q.size(), 32'd0);
      exp_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_mode", {30'd0, S1, S0}, 32'd0);
    check("rst_data", {28'd0, A, B, C, D}, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    CR = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    issue(T_LOAD, 4'b1010, 1'b0, 4'd0);
    check("load_mode", {30'd0, S1, S0}, 32'd3);
    check("load_pins", {28'd0, A, B, C, D}, 32'b1010);
    drain();

    issue(T_LOAD, 4'b1000, 1'b0, 4'd5);
    issue(T_ROTR, 4'b0000, 1'b0, 4'd4);
    drain();

    issue(T_LOAD, 4'b0001, 1'b0, 4'd0);
    issue(T_SHLF, 4'b0000, 1'b1, 4'd3);
    issue(T_LOAD, 4'b0101, 1'b0, 4'd0);   // held valid through the SHL run
    drain();

    issue(T_NOP, 4'b1111, 1'b1, 4'd3);
    drain();
    issue(T_ROTR, 4'b0000, 1'b0, 4'd0);
    drain();
    issue(T_RSVD, 4'b1111, 1'b1, 4'd5);
    drain();
    check("q_after_rsvd", {28'd0, q}, {28'd0, model_q});

`ifdef SHIFT_CTRL_TWIST_EN
    issue(T_LOAD, 4'b0000, 1'b0, 4'd0);
    issue(T_TWIST, 4'b0000, 1'b0, 4'd8);
    drain();
`else
    issue(T_TWIST, 4'b0000, 1'b0, 4'd3);
    drain();
    check("q_after_110", {28'd0, q}, {28'd0, model_q});
`endif

    issue(T_LOAD, 4'b1011, 1'b0, 4'd0);
    issue(T_SHRF, 4'b0000, 1'b0, 4'd15);
    issue(T_LOAD, 4'b0110, 1'b0, 4'd0);
    issue(T_SHLF, 4'b0000, 1'b1, 4'd2);
    drain();

    issue(T_LOAD, 4'b1001, 1'b0, 4'd0);
    issue(T_ROTL, 4'b0000, 1'b0, 4'd7);
    repeat (3) @(negedge clk);
    CR = 1'b0;
    #1;
    exp_q.delete();
    done_q.delete();
    model_q = 4'd0;
    check("mid_rst_mode", {30'd0, S1, S0}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_q", {28'd0, q}, 32'd0);
    @(negedge clk);
    CR = 1'b1;
    @(negedge clk);
    issue(T_LOAD, 4'b0110, 1'b0, 4'd0);
    drain();
    check("q_final", {28'd0, q}, 32'b0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
